byte_serial_add_seq: RTL and testbench



---
 rtl/byte_serial_add_seq_if.sv | 41 ++++
 rtl/byte_serial_add_seq.sv | 114 +++++++++++
 tb/tb_byte_serial_add_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/byte_serial_add_seq_if.sv
// Operand/result and external 8-bit adder signals for byte_serial_add_seq.
// BYTE_SERIAL_ADD_SEQ_OVF_EN adds the signed-overflow flag ovf.
interface byte_serial_add_seq_if #(
    parameter int unsigned NBYTES = 4
) ();
    localparam int unsigned W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
    logic         ovf;
`endif
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_carry;

    // Sequencer side: takes requests and adder results, drives status and adder operands.
    modport slave (
        input  start, op_a, op_b, cin, add_sum, add_carry,
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
        output ovf,
`endif
        output busy, done, result, cout, add_a, add_b, add_cin
    );

    modport master (
        output start, op_a, op_b, cin, add_sum, add_carry,
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
        input  ovf,
`endif
        input  busy, done, result, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/byte_serial_add_seq.sv
// W-bit adder sequencer: feeds one byte slice per clock to an external 8-bit adder, chaining carry.
// Define BYTE_SERIAL_ADD_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module byte_serial_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    byte_serial_add_seq_if.slave  bus
);
    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            c_q, c_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        idx_d       = idx_q;
        result_d    = result_q;
        cout_d      = cout_q;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        bus.add_a   = 8'h00;
        bus.add_b   = 8'h00;
        bus.add_cin = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_d      = bus.op_a;
                    b_d      = bus.op_b;
                    c_d      = bus.cin;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = StRun;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // start is deliberately not looked at here: operands stay as latched.
                bus.add_a   = a_q[8*int'(idx_q) +: 8];
                bus.add_b   = b_q[8*int'(idx_q) +: 8];
                bus.add_cin = c_q;
                result_d[8*int'(idx_q) +: 8] = bus.add_sum;
                c_d   = bus.add_carry;
                idx_d = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    cout_d  = bus.add_carry;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_sum[7] != a_q[W-1]);
`endif
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pure state decodes so start has no combinational path to busy/done.
    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Scoreboard bench for byte_serial_add_seq (NBYTES=4 main instance, NBYTES=1 side instance).
// Honours BYTE_SERIAL_ADD_SEQ_OVF_EN to check ovf.
module tb_byte_serial_add_seq;
    localparam int unsigned NB = 4;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    byte_serial_add_seq_if #(.NBYTES(NB)) bus ();
    byte_serial_add_seq_if #(.NBYTES(1))  bus1 ();

    byte_serial_add_seq #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    byte_serial_add_seq #(.NBYTES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Behavioural 8-bit adders standing in for the external stage.
    assign {bus.add_carry, bus.add_sum} =
        {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'h00, bus.add_cin};
    assign {bus1.add_carry, bus1.add_sum} =
        {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {8'h00, bus1.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycles=%0d required=finish", cyc);
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
            end else begin
                if (bus.busy) busy_run++;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=1 required=0 result=0x%0h",
                                 bus.result);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 64'(bus.result), 64'(e.res));
                        check("cout", 64'(bus.cout), 64'(e.co));
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
                        check("ovf", 64'(bus.ovf), 64'(e.ov));
`endif
                        check("done_cycle", 64'(cyc), 64'(e.cyc));
                        check("busy_len", 64'(busy_run), 64'(NB));
                    end
                    busy_run = 0;
                end
            end
        end
    end

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] er, input logic ec, input logic eo);
        exp_t e;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        @(posedge clk);
        #1;
        e.res = er;
        e.co  = ec;
        e.ov  = eo;
        e.cyc = cyc + NB;
        exp_q.push_back(e);
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_20");
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.cin    = 1'b0;
        bus1.start = 1'b0;
        bus1.op_a  = '0;
        bus1.op_b  = '0;
        bus1.cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_add_a", 64'(bus.add_a), 64'd0);
        check("rst_add_b", 64'(bus.add_b), 64'd0);
        check("rst_add_cin", 64'(bus.add_cin), 64'd0);
`ifdef BYTE_SERIAL_ADD_SEQ_OVF_EN
        check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Carry chain across byte 0 -> 1.
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);

        // Full wrap with carry-in.
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        wait_done();
        @(negedge clk);

        // Mixed, then a start held in the DONE cycle is accepted back-to-back.
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
        wait_done();
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);

        // Start pulsed in RUN cycle 2 must be ignored.
        run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'hFFFF_FFFF;
        bus.op_b  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        @(negedge clk);

        // Reset asserted in RUN cycle 3 aborts the op.
        run_op(32'h1111_1111, 32'h2222_2222, 1'b1, 32'h3333_3334, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);

        // Signed overflow boundary.
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // NBYTES=1 instance: single RUN cycle, done right after E1.
        bus1.start = 1'b1;
        bus1.op_a  = 8'hC8;
        bus1.op_b  = 8'h64;
        bus1.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        @(negedge clk);
        check("n1_busy", 64'(bus1.busy), 64'd1);
        check("n1_done_early", 64'(bus1.done), 64'd0);
        check("n1_add_a", 64'(bus1.add_a), 64'hC8);
        @(negedge clk);
        check("n1_done", 64'(bus1.done), 64'd1);
        check("n1_busy_off", 64'(bus1.busy), 64'd0);
        check("n1_result", 64'(bus1.result), 64'h2C);
        check("n1_cout", 64'(bus1.cout), 64'd1);
        @(negedge clk);
        check("n1_done_pulse", 64'(bus1.done), 64'd0);
        check("n1_result_hold", 64'(bus1.result), 64'h2C);

        repeat (4) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
